// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-ported data memory; one transaction per three cycles.
// Build option: define DMEM_ARB_ROUND_ROBIN_EN for round-robin contention (default: port 0 priority).
module dmem_arbiter #(
    parameter int ADDR_LIMIT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_valid_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [1:0]  m0_mode_i,
    input  logic [31:0] m0_wdata_i,
    input  logic        m1_valid_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [1:0]  m1_mode_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m0_ready_o,
    output logic        m0_rsp_valid_o,
    output logic [31:0] m0_rsp_rdata_o,
    output logic        m0_rsp_err_o,
    output logic        m1_ready_o,
    output logic        m1_rsp_valid_o,
    output logic [31:0] m1_rsp_rdata_o,
    output logic        m1_rsp_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [1:0]  mem_mode_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [32:0] LIMIT33 = 33'(ADDR_LIMIT);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        grant_any, grant_sel, err;
    logic [32:0] last_byte;
    logic [31:0] load_data;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic        last_grant_q, last_grant_d;
`endif

    always_comb begin
        grant_any = m0_valid_i | m1_valid_i;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (m0_valid_i && m1_valid_i) grant_sel = ~last_grant_q;
        else                          grant_sel = m1_valid_i;
`else
        grant_sel = ~m0_valid_i & m1_valid_i;
`endif
    end

    // Last byte touched, in 33 bits so a wrap past 0xFFFFFFFF still lands above the limit.
    always_comb begin
        case (mode_q)
            2'b00:   last_byte = {1'b0, addr_q};
            2'b01:   last_byte = {1'b0, addr_q} + 33'd1;
            default: last_byte = {1'b0, addr_q} + 33'd3;
        endcase
        err = (mode_q == 2'b11)
            || (mode_q == 2'b01 && addr_q[0])
            || (mode_q == 2'b10 && addr_q[1:0] != 2'b00)
            || (last_byte >= LIMIT33);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m0_ready_o     = !rst_i && state_q == IDLE && grant_any && !grant_sel;
        m1_ready_o     = !rst_i && state_q == IDLE && grant_any && grant_sel;
        mem_we_o       = !rst_i && state_q == ACCESS && we_q && !err;
        mem_addr_o     = rst_i ? 32'd0 : addr_q;
        mem_mode_o     = rst_i ? 2'd0 : mode_q;
        mem_wdata_o    = rst_i ? 32'd0 : wdata_q;
        m0_rsp_valid_o = !rst_i && state_q == RESP && !grant_q;
        m1_rsp_valid_o = !rst_i && state_q == RESP && grant_q;
        m0_rsp_err_o   = m0_rsp_valid_o && err;
        m1_rsp_err_o   = m1_rsp_valid_o && err;
        m0_rsp_rdata_o = rst_i ? 32'd0 : rdata0_q;
        m1_rsp_rdata_o = rst_i ? 32'd0 : rdata1_q;
    end

    // Request latch on grant; per-port response data captured at the end of ACCESS.
    always_comb begin
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        mode_d    = mode_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        load_data = (we_q || err) ? 32'd0 : mem_rdata_i;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        if (state_q == IDLE && grant_any) begin
            grant_d = grant_sel;
            we_d    = grant_sel ? m1_we_i    : m0_we_i;
            addr_d  = grant_sel ? m1_addr_i  : m0_addr_i;
            mode_d  = grant_sel ? m1_mode_i  : m0_mode_i;
            wdata_d = grant_sel ? m1_wdata_i : m0_wdata_i;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_d = grant_sel;
`endif
        end
        if (state_q == ACCESS) begin
            if (grant_q) rdata1_d = load_data;
            else         rdata0_d = load_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            mode_q   <= 2'b00;
            wdata_q  <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            mode_q   <= mode_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: per-port request queues, a transaction-level
// reference model and a byte-array memory attached to the memory-side port.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int LIMIT = 1024;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic m0_valid, m0_we, m1_valid, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0] m0_mode, m1_mode;
    logic m0_ready, m0_rsp_valid, m0_rsp_err, m1_ready, m1_rsp_valid, m1_rsp_err;
    logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
    logic mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0] mem_mode;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_valid_i(m0_valid), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_mode_i(m0_mode), .m0_wdata_i(m0_wdata),
        .m1_valid_i(m1_valid), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_mode_i(m1_mode), .m1_wdata_i(m1_wdata),
        .m0_ready_o(m0_ready), .m0_rsp_valid_o(m0_rsp_valid), .m0_rsp_rdata_o(m0_rsp_rdata), .m0_rsp_err_o(m0_rsp_err),
        .m1_ready_o(m1_ready), .m1_rsp_valid_o(m1_rsp_valid), .m1_rsp_rdata_o(m1_rsp_rdata), .m1_rsp_err_o(m1_rsp_err),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_mode_o(mem_mode), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    typedef struct packed { logic we; logic [31:0] addr; logic [1:0] mode; logic [31:0] wdata; } req_t;
    typedef struct packed { int cyc; logic [31:0] rdata; logic err; } rsp_t;

    req_t rq [2][$];
    rsp_t sb [2][$];
    int   glog [$];
    logic [7:0] tmem [LIMIT];
    logic [7:0] rmem [LIMIT];

    int cyc = 0;
    int n_vec = 0;
    int n_mis = 0;
    int next_ok = 0;
    bit mlast = 1'b1;
    bit pw_valid = 1'b0;
    int pw_cyc = 0;
    req_t pw;
    logic [31:0] last_rd [2];
    logic [31:0] last_rsp_rd [2];
    logic        last_rsp_err [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] byte_at(bit side, longint a);
        if (a < 0 || a >= LIMIT) return 8'h00;
        return side ? rmem[int'(a)] : tmem[int'(a)];
    endfunction

    // Memory semantics: little-endian, byte and half loads sign-extended.
    function automatic logic [31:0] mem_load(bit side, logic [31:0] a, logic [1:0] m);
        logic [31:0] v = 32'd0;
        longint base = longint'({32'd0, a});
        for (int i = 0; i < 4; i++)
            if (i < (1 << m)) v[8*i +: 8] = byte_at(side, base + i);
        if (m == 2'b00) v = {{24{v[7]}}, v[7:0]};
        if (m == 2'b01) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic void mem_store(bit side, logic [31:0] a, logic [1:0] m, logic [31:0] d);
        longint base = longint'({32'd0, a});
        for (int i = 0; i < 4; i++)
            if (i < (1 << m) && base + i < LIMIT) begin
                if (side) rmem[int'(base + i)] = d[8*i +: 8];
                else      tmem[int'(base + i)] = d[8*i +: 8];
            end
    endfunction

    function automatic bit ref_err(logic [31:0] a, logic [1:0] m);
        longint ea = longint'({32'd0, a});
        longint sz = longint'(1) << m;
        if (m == 2'b11) return 1'b1;
        if (ea % sz != 0) return 1'b1;
        return (ea + sz - 1) >= LIMIT;
    endfunction

    always_comb mem_rdata = mem_load(1'b0, mem_addr, mem_mode);
    always @(posedge clk) if (mem_we) mem_store(1'b0, mem_addr, mem_mode, mem_wdata);

    // Reference model: arbitration, memory-write expectation and response prediction.
    always @(negedge clk) begin
        logic [1:0] v, rdy, exp_rdy;
        logic exp_we;
        req_t r;
        rsp_t e;
        int p;
        v = {m1_valid, m0_valid};
        rdy = {m1_ready, m0_ready};
        exp_we = pw_valid && pw_cyc == cyc && !rst;
        if (exp_we || mem_we) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            if (exp_we) begin
                chk("mem_addr", mem_addr, pw.addr);
                chk("mem_wdata", mem_wdata, pw.wdata);
                chk("mem_mode", {30'd0, mem_mode}, {30'd0, pw.mode});
                mem_store(1'b1, pw.addr, pw.mode, pw.wdata);
            end
        end
        if (pw_valid && pw_cyc <= cyc) pw_valid = 1'b0;
        if (rst) begin
            chk("ready_in_reset", {30'd0, rdy}, 32'd0);
            sb[0].delete();
            sb[1].delete();
            next_ok = cyc + 1;
            mlast = 1'b1;
        end else begin
            exp_rdy = 2'b00;
            if (cyc >= next_ok && v != 2'b00) begin
                if (v == 2'b11) exp_rdy = (RR && mlast == 1'b0) ? 2'b10 : 2'b01;
                else            exp_rdy = v;
            end
            if (v != 2'b00 || rdy != 2'b00) chk("ready", {30'd0, rdy}, {30'd0, exp_rdy});
            if (rdy != 2'b00) begin
                p = rdy[1] ? 1 : 0;
                r = p ? req_t'{m1_we, m1_addr, m1_mode, m1_wdata} : req_t'{m0_we, m0_addr, m0_mode, m0_wdata};
                if (rq[p].size() != 0) void'(rq[p].pop_front());
                e.cyc = cyc + 2;
                e.err = ref_err(r.addr, r.mode);
                e.rdata = (r.we || e.err) ? 32'd0 : mem_load(1'b1, r.addr, r.mode);
                sb[p].push_back(e);
                if (r.we && !e.err) begin
                    pw = r;
                    pw_cyc = cyc + 1;
                    pw_valid = 1'b1;
                end
                next_ok = cyc + 3;
                mlast = p[0];
                glog.push_back(p);
            end
        end
    end

    task automatic rsp_pins(input int p, output logic rv, output logic re, output logic [31:0] rd);
        rv = p ? m1_rsp_valid : m0_rsp_valid;
        re = p ? m1_rsp_err   : m0_rsp_err;
        rd = p ? m1_rsp_rdata : m0_rsp_rdata;
    endtask

    // Monitor: pops the scoreboard whenever a response strobe appears.
    always @(negedge clk) begin
        logic rv, re;
        logic [31:0] rd;
        rsp_t e;
        #1;
        if (rst) begin
            chk("outputs_in_reset", {31'd0, |{m0_ready, m1_ready, m0_rsp_valid, m0_rsp_err, m0_rsp_rdata,
                m1_rsp_valid, m1_rsp_err, m1_rsp_rdata, mem_we, mem_addr, mem_mode, mem_wdata}}, 32'd0);
            last_rd[0] = 32'd0;
            last_rd[1] = 32'd0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rsp_pins(p, rv, re, rd);
                if (rv) begin
                    if (sb[p].size() == 0) begin
                        chk($sformatf("rsp%0d_unexpected", p), 32'd1, 32'd0);
                    end else begin
                        e = sb[p].pop_front();
                        chk($sformatf("rsp%0d_cycle", p), cyc, e.cyc);
                        chk($sformatf("rsp%0d_rdata", p), rd, e.rdata);
                        chk($sformatf("rsp%0d_err", p), {31'd0, re}, {31'd0, e.err});
                    end
                    last_rd[p] = rd;
                    last_rsp_rd[p] = rd;
                    last_rsp_err[p] = re;
                end else begin
                    if (re || rd !== last_rd[p])
                        chk($sformatf("rsp%0d_idle_hold", p), {re, rd[30:0]}, {1'b0, last_rd[p][30:0]});
                    if (sb[p].size() != 0 && sb[p][0].cyc <= cyc) begin
                        chk($sformatf("rsp%0d_missing", p), 32'd0, 32'd1);
                        void'(sb[p].pop_front());
                    end
                end
            end
        end
    end

    task automatic drive();
        if (rq[0].size() != 0) begin
            m0_valid = 1'b1;
            {m0_we, m0_addr, m0_mode, m0_wdata} = rq[0][0];
        end else begin
            m0_valid = 1'b0;
            {m0_we, m0_addr, m0_mode, m0_wdata} = {$urandom, $urandom, $urandom};
        end
        if (rq[1].size() != 0) begin
            m1_valid = 1'b1;
            {m1_we, m1_addr, m1_mode, m1_wdata} = rq[1][0];
        end else begin
            m1_valid = 1'b0;
            {m1_we, m1_addr, m1_mode, m1_wdata} = {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic push(input int p, input logic we, input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
        rq[p].push_back(req_t'{we, a, m, d});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rq[0].size() != 0 || rq[1].size() != 0 || sb[0].size() != 0 || sb[1].size() != 0 || pw_valid)
               && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_done", (n >= budget) ? 32'd1 : 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic single(input int p, input logic we, input logic [31:0] a, input logic [1:0] m,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        push(p, we, a, m, d);
        drain(100);
        chk($sformatf("dir_p%0d_a%0h_rdata", p, a), last_rsp_rd[p], exp_rd);
        chk($sformatf("dir_p%0d_a%0h_err", p, a), {31'd0, last_rsp_err[p]}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] saved, a;
        logic [1:0] m;
        int base, n;
        for (int i = 0; i < LIMIT; i++) begin
            tmem[i] = 8'($urandom);
            rmem[i] = tmem[i];
        end
        last_rd[0] = 0; last_rd[1] = 0;
        last_rsp_rd[0] = 0; last_rsp_rd[1] = 0;
        last_rsp_err[0] = 0; last_rsp_err[1] = 0;
        rst = 1'b1;
        drive();
        fork
            forever begin
                @(posedge clk);
                #1;
                drive();
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        single(0, 1'b1, 32'd4, 2'b10, 32'h88913416, 32'd0, 1'b0);
        single(0, 1'b0, 32'd4, 2'b10, 32'd0, 32'h88913416, 1'b0);
        single(1, 1'b0, 32'd7, 2'b00, 32'd0, 32'hFFFFFF88, 1'b0);
        single(0, 1'b0, 32'd6, 2'b10, 32'd0, 32'd0, 1'b1);
        single(0, 1'b0, 32'd0, 2'b11, 32'd0, 32'd0, 1'b1);
        single(0, 1'b1, 32'd1023, 2'b01, 32'h0000BEEF, 32'd0, 1'b1);
        single(1, 1'b0, 32'hFFFFFFFE, 2'b01, 32'd0, 32'd0, 1'b1);

        base = glog.size();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 32'(16 + 4 * i), 2'b10, 32'd0);
            push(1, 1'b0, 32'(32 + 4 * i), 2'b10, 32'd0);
        end
        drain(200);
        for (int i = 0; i < 4; i++)
            chk($sformatf("contention_grant%0d", i), glog[base + i], RR ? (i % 2) : 0);

        saved = {tmem[11], tmem[10], tmem[9], tmem[8]};
        push(0, 1'b1, 32'd8, 2'b10, ~saved);
        n = 0;
        while (rq[0].size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        push(0, 1'b0, 32'd8, 2'b10, 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drain(100);
        chk("rst_access_mem_unchanged", {tmem[11], tmem[10], tmem[9], tmem[8]}, saved);
        chk("rst_access_load_old", last_rsp_rd[0], saved);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            for (int p = 0; p < 2; p++) begin
                if (rq[p].size() < 2 && $urandom_range(0, 2) == 0) begin
                    m = 2'($urandom_range(0, 3));
                    case ($urandom_range(0, 9))
                        0: a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
                        1: a = 32'(LIMIT - 4 + $urandom_range(0, 3));
                        default: a = 32'($urandom_range(0, LIMIT - 1));
                    endcase
                    if (m != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << m) - 32'd1);
                    push(p, 1'($urandom_range(0, 1)), a, m, $urandom);
                end
            end
        end
        drain(3000);
        n = 0;
        for (int i = 0; i < LIMIT; i++) if (tmem[i] !== rmem[i]) n++;
        chk("final_mem_bytes_differ", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
